filt_decim_out: RTL and testbench

- Downstream stage of the 4-tap IIR filter.
- Consumes the filter's signed output sample stream, performs boxcar average-and-decimate by DEC, and saturates the result to the output width.
- Buffers decimated samples in a small FIFO.
- Presents them to the next consumer over a valid/ready handshake.

---
 rtl/filt_pkg.sv | 25 ++
 rtl/filt_decim_out_if.sv | 29 ++
 rtl/filt_sync_fifo.sv | 69 ++++++
 rtl/filt_decim_out.sv | 96 +++++++++
 tb/tb_filt_decim_out.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/filt_pkg.sv
// filt_pkg: definitions shared by the IIR filter and its downstream stages.
//   NBINPUT_DEF / NBOUTPUT_DEF : default sample widths, shared with the filter
//   LOG2_DEC_DEF               : default log2 of the decimation factor
//   ACC_W                      : accumulator width for the default configuration
//   sat_signed(value, width)   : clamps a signed value to a width-bit signed range
package filt_pkg;

  localparam int NBINPUT_DEF  = 8;
  localparam int NBOUTPUT_DEF = 8;
  localparam int LOG2_DEC_DEF = 2;
  localparam int ACC_W        = NBINPUT_DEF + LOG2_DEC_DEF;

  // Clamp value into [-2**(width-1), 2**(width-1)-1]; width must be 2..31.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (width - 1));
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/filt_decim_out_if.sv
// filt_decim_out_if: sample stream into the decimator and the valid/ready
// stream out of it.
//   in_valid/in_data   : filter output samples (no back-pressure)
//   out_valid/out_ready/out_data : decimated samples to the next consumer
// Modports: master = producer/consumer side, slave = the decimator.
interface filt_decim_out_if
  import filt_pkg::*;
#(
  parameter int NBINPUT  = NBINPUT_DEF,
  parameter int NBOUTPUT = NBOUTPUT_DEF
);

  logic                       in_valid;
  logic signed [NBINPUT-1:0]  in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [NBOUTPUT-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/filt_sync_fifo.sv
// filt_sync_fifo: single-clock FIFO with a registered head.
//   clk, rst_n (async, active-low), clear (sync flush)
//   push/wdata : write request; accepted when not full, or when full with a pop
//   pop        : read request; ignored when empty
//   rdata      : registered head entry, holds its value while empty or not popped
//   full, empty, level : occupancy status
module filt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [LW-1:0]    cnt;
  logic             do_pop;
  logic             do_push;

  assign empty      = (cnt == '0);
  assign full       = (cnt == LW'(DEPTH));
  assign level      = cnt;
  assign do_pop     = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_nxt = rd_ptr + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      rdata  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
      cnt <= cnt + LW'(do_push) - LW'(do_pop);
      // Head register mirrors mem[rd_ptr]; refill it from storage when the
      // next entry already exists, otherwise straight from the write port.
      if (do_pop && (cnt > LW'(1)))
        rdata <= mem[rd_ptr_nxt];
      else if (do_push && (empty || (do_pop && (cnt == LW'(1)))))
        rdata <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/filt_decim_out.sv
// filt_decim_out: boxcar average-and-decimate stage behind the 4-tap IIR filter.
// Sums DEC = 2**LOG2_DEC valid samples, divides by DEC with an arithmetic shift,
// saturates to NBOUTPUT bits and queues the result in a FIFO_DEPTH-entry FIFO.
//   clk, rst_n (async, active-low)
//   clear      : sync flush of accumulator, counter, FIFO and overflow flag
//   bus        : in_valid/in_data in, out_valid/out_ready/out_data out
//   overflow   : sticky, a decimated sample was dropped on a full FIFO
//   fifo_level : current FIFO occupancy
// Build option: define FILT_DECIM_ROUND_EN for round-half-up instead of floor.
module filt_decim_out
  import filt_pkg::*;
#(
  parameter int NBINPUT    = NBINPUT_DEF,
  parameter int NBOUTPUT   = NBOUTPUT_DEF,
  parameter int LOG2_DEC   = LOG2_DEC_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  filt_decim_out_if.slave             bus,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int DEC   = 2 ** LOG2_DEC;
  localparam int SUM_W = NBINPUT + LOG2_DEC;

  logic signed [SUM_W-1:0]    acc;
  logic signed [SUM_W-1:0]    sum;
  logic signed [31:0]         res_wide;
  logic signed [NBOUTPUT-1:0] res_sat;
  logic [LOG2_DEC-1:0]        cnt;
  logic                       last;
  logic                       pop;
  logic                       fifo_full;
  logic                       fifo_empty;

  assign last = bus.in_valid && (cnt == LOG2_DEC'(DEC - 1));
  assign sum  = acc + SUM_W'(bus.in_data);
  assign pop  = bus.out_valid && bus.out_ready;

`ifdef FILT_DECIM_ROUND_EN
  // One extra bit so the rounding offset cannot wrap the full-scale sum.
  logic signed [SUM_W:0] sum_rnd;
  assign sum_rnd  = (SUM_W + 1)'(sum) + (SUM_W + 1)'(2 ** (LOG2_DEC - 1));
  assign res_wide = 32'(sum_rnd >>> LOG2_DEC);
`else
  assign res_wide = 32'(sum >>> LOG2_DEC);
`endif

  assign res_sat = NBOUTPUT'(sat_signed(res_wide, NBOUTPUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        if (last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + LOG2_DEC'(1);
        end
      end
      // Block result is lost only when the FIFO is full and nothing leaves.
      if (last && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  filt_sync_fifo #(
    .WIDTH (NBOUTPUT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (last),
    .wdata (res_sat),
    .pop   (bus.out_ready),
    .rdata (bus.out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bus.out_valid = !fifo_empty;

endmodule

// File: tb/tb_filt_decim_out.sv
// tb_filt_decim_out: directed vectors for filt_decim_out, an 8-bit-output and a
// 6-bit-output instance fed from the same stream.
module tb_filt_decim_out;

`ifdef FILT_DECIM_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic overflow8, overflow6;
  logic [2:0] level8, level6;

  always #5 clk = ~clk;

  filt_decim_out_if #(.NBINPUT(8), .NBOUTPUT(8)) bus8 ();
  filt_decim_out_if #(.NBINPUT(8), .NBOUTPUT(6)) bus6 ();

  assign bus6.in_valid  = bus8.in_valid;
  assign bus6.in_data   = bus8.in_data;
  assign bus6.out_ready = bus8.out_ready;

  filt_decim_out #(.NBINPUT(8), .NBOUTPUT(8), .LOG2_DEC(2), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus8),
    .overflow(overflow8), .fifo_level(level8)
  );

  filt_decim_out #(.NBINPUT(8), .NBOUTPUT(6), .LOG2_DEC(2), .FIFO_DEPTH(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus6),
    .overflow(overflow6), .fifo_level(level6)
  );

  typedef struct {
    int d0, d1, d2, d3;
    int f8, r8, f6, r6;
  } vec_t;

  vec_t vecs [9];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'(v);
    tick();
    bus8.in_valid = 1'b0;
  endtask

  task automatic send_block(input int v);
    for (int k = 0; k < 4; k++) send(v);
  endtask

  task automatic setv(input int i, input int a, input int b, input int c, input int d,
                      input int f8, input int r8, input int f6, input int r6);
    vecs[i].d0 = a; vecs[i].d1 = b; vecs[i].d2 = c; vecs[i].d3 = d;
    vecs[i].f8 = f8; vecs[i].r8 = r8; vecs[i].f6 = f6; vecs[i].r6 = r6;
  endtask

  initial begin
    setv(0,    1,    2,    3,    4,    2,    3,   2,   3);
    setv(1,   -1,   -1,   -1,   -2,   -2,   -1,  -2,  -1);
    setv(2,  127,  127,  127,  127,  127,  127,  31,  31);
    setv(3, -128, -128, -128, -128, -128, -128, -32, -32);
    setv(4,  100,  100,  100,  100,  100,  100,  31,  31);
    setv(5, -100, -100, -100, -100, -100, -100, -32, -32);
    setv(6,    5,    6,    7,    9,    6,    7,   6,   7);
    setv(7,    0,    0,    0,    3,    0,    1,   0,   1);
    setv(8,   -2,    0,    0,    0,   -1,    0,  -1,   0);

    rst_n          = 1'b0;
    clear          = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.out_ready = 1'b1;
    #12;
    chk("reset out_valid", int'(bus8.out_valid), 0);
    chk("reset out_data", int'(bus8.out_data), 0);
    chk("reset overflow", int'(overflow8), 0);
    chk("reset level", int'(level8), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Average/decimate vectors, consumer always ready
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].d0);
      send(vecs[i].d1);
      send(vecs[i].d2);
      chk($sformatf("vec%0d early valid", i), int'(bus8.out_valid), 0);
      send(vecs[i].d3);
      chk($sformatf("vec%0d valid8", i), int'(bus8.out_valid), 1);
      chk($sformatf("vec%0d data8", i), int'(bus8.out_data), ROUND ? vecs[i].r8 : vecs[i].f8);
      chk($sformatf("vec%0d valid6", i), int'(bus6.out_valid), 1);
      chk($sformatf("vec%0d data6", i), int'(bus6.out_data), ROUND ? vecs[i].r6 : vecs[i].f6);
      tick();
      chk($sformatf("vec%0d one-cycle valid", i), int'(bus8.out_valid), 0);
    end

    // Overflow: five blocks with the consumer stalled
    bus8.out_ready = 1'b0;
    for (int b = 0; b < 5; b++) send_block(8);
    chk("ovf level", int'(level8), 4);
    chk("ovf flag", int'(overflow8), 1);
    chk("ovf head", int'(bus8.out_data), 8);
    tick();
    tick();
    chk("ovf head stable", int'(bus8.out_data), 8);
    bus8.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf drain%0d valid", k), int'(bus8.out_valid), 1);
      chk($sformatf("ovf drain%0d data", k), int'(bus8.out_data), 8);
      tick();
    end
    chk("ovf drained valid", int'(bus8.out_valid), 0);
    chk("ovf drained level", int'(level8), 0);
    chk("ovf sticky", int'(overflow8), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear overflow", int'(overflow8), 0);
    chk("clear out_data", int'(bus8.out_data), 0);

    // Full FIFO with the fifth block landing on a pop
    bus8.out_ready = 1'b0;
    for (int b = 1; b <= 4; b++) send_block(b);
    chk("full level", int'(level8), 4);
    chk("full head", int'(bus8.out_data), 1);
    send(5);
    send(5);
    send(5);
    bus8.out_ready = 1'b1;
    send(5);
    chk("push+pop level", int'(level8), 4);
    chk("push+pop overflow", int'(overflow8), 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("order%0d", k), int'(bus8.out_data), k + 2);
      tick();
    end
    chk("order empty", int'(bus8.out_valid), 0);

    // Clear in the middle of a block, with in_valid high during clear
    send(10);
    send(10);
    clear         = 1'b1;
    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'd99;
    tick();
    clear         = 1'b0;
    bus8.in_valid = 1'b0;
    send_block(4);
    chk("clear-mid valid", int'(bus8.out_valid), 1);
    chk("clear-mid data", int'(bus8.out_data), 4);
    tick();

    // Asynchronous reset in the middle of a block
    send(10);
    send(10);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_data", int'(bus8.out_data), 0);
    chk("async rst level", int'(level8), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    send_block(4);
    chk("rst-mid valid", int'(bus8.out_valid), 1);
    chk("rst-mid data", int'(bus8.out_data), 4);
    tick();

    // Gaps inside a block, then popping an empty FIFO
    send(1);
    tick();
    send(2);
    tick();
    tick();
    send(3);
    tick();
    chk("gap no early valid", int'(bus8.out_valid), 0);
    send(4);
    chk("gap valid", int'(bus8.out_valid), 1);
    chk("gap data", int'(bus8.out_data), ROUND ? 3 : 2);
    tick();
    tick();
    chk("empty pop valid", int'(bus8.out_valid), 0);
    chk("empty pop level", int'(level8), 0);
    chk("empty hold data", int'(bus8.out_data), ROUND ? 3 : 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
